sm_add_norm_pipe: RTL and testbench

Parametrised, pipelined sign-magnitude adder/subtractor with leading-one detection and left normalisation. It is the streaming successor to the combinational significand adder in the floating-point datapath. It accepts one operand pair per cycle under a valid/ready handshake and returns the signed sum as sign plus normalised magnitude, together with the leading-one position and a zero flag. Typical uses are the FP add/sub unit and any block that needs a normalised sign-magnitude sum.

---
 rtl/sm_add_norm_pipe.sv | 142 ++++++++++++++
 tb/tb_sm_add_norm_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_add_norm_pipe.sv
// Three-stage elastic sign-magnitude adder/subtractor with leading-one detect
// and left normalisation; one operand pair per cycle under valid/ready.
module sm_add_norm_pipe #(
    parameter int W     = 28,
    parameter int PW    = $clog2(W),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       result,
    output logic [PW-1:0]    position,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    function automatic logic [PW-1:0] lead_one(input logic [W-1:0] m);
        logic [PW-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (m[i]) p = PW'(i);
        end
        return p;
    endfunction

    // Stage registers
    logic             s1_valid;
    logic [W:0]       s1_sum;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic             s2_sign;
    logic [W-1:0]     s2_mag;
    logic [PW-1:0]    s2_pos;
    logic             s2_zero;
    logic [TAG_W-1:0] s2_tag;

    // Load enables ripple back from the consumer so a full pipe still moves
    // in the same cycle the head result leaves.
    logic ld1, ld2, ld3;

    always_comb begin
        ld3      = !out_valid || out_ready;
        ld2      = !s2_valid || ld3;
        ld1      = !s1_valid || ld2;
        in_ready = ld1;
    end

    // Stage 1: sign-magnitude to two's complement, then add
    logic             b_sign;
    logic [W:0]       a_ext, b_ext, a_tc, b_tc, sum_n;

    always_comb begin
        b_sign = b[W-1] ^ op;
        a_ext  = {2'b00, a[W-2:0]};
        b_ext  = {2'b00, b[W-2:0]};
        // A zero magnitude with sign set negates to zero, never to -2^(W-1).
        a_tc   = a[W-1] ? -a_ext : a_ext;
        b_tc   = b_sign ? -b_ext : b_ext;
        sum_n  = a_tc + b_tc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_tag   <= '0;
        end else begin
            if (ld1) s1_valid <= in_valid;
            if (ld1 && in_valid) begin
                s1_sum <= sum_n;
                s1_tag <= in_tag;
            end
        end
    end

    // Stage 2: magnitude, leading-one position, zero flag
    logic [W-1:0]  mag_n;
    logic          zero_n;
    logic [PW-1:0] pos_n;

    always_comb begin
        mag_n  = s1_sum[W] ? (~s1_sum[W-1:0] + W'(1)) : s1_sum[W-1:0];
        zero_n = (mag_n == '0);
        pos_n  = lead_one(mag_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_pos   <= '0;
            s2_zero  <= 1'b0;
            s2_tag   <= '0;
        end else begin
            if (ld2) s2_valid <= s1_valid;
            if (ld2 && s1_valid) begin
                s2_sign <= s1_sum[W] && !zero_n;
                s2_mag  <= mag_n;
                s2_pos  <= pos_n;
                s2_zero <= zero_n;
                s2_tag  <= s1_tag;
            end
        end
    end

    // Stage 3: left normalise so the leading one lands on bit W-1
    logic [PW-1:0] shamt;
    logic [W-1:0]  norm_n;

    always_comb begin
        shamt  = PW'(W - 1) - s2_pos;
        norm_n = s2_mag << shamt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            position  <= '0;
            zero      <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (ld3) out_valid <= s2_valid;
            if (ld3 && s2_valid) begin
                result   <= {s2_sign, norm_n};
                position <= s2_pos;
                zero     <= s2_zero;
                out_tag  <= s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_sm_add_norm_pipe.sv
// Self-checking bench for sm_add_norm_pipe: directed vectors, backpressure,
// asynchronous reset mid-stream and randomized traffic against an integer model.
module tb_sm_add_norm_pipe;

    localparam int W     = 28;
    localparam int PW    = $clog2(W);
    localparam int TAG_W = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             op        = 1'b0;
    logic             out_ready = 1'b1;
    logic [W-1:0]     a         = '0;
    logic [W-1:0]     b         = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             in_ready, out_valid, zero;
    logic [W:0]       result;
    logic [PW-1:0]    position;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W:0]       res;
        logic [PW-1:0]    pos;
        logic             z;
        logic [TAG_W-1:0] tag;
    } exp_t;

    sm_add_norm_pipe #(.W(W), .PW(PW), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .position(position), .zero(zero), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference: signed integer sum, then normalise by plain arithmetic.
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic opi, input logic [TAG_W-1:0] t);
        longint va, vb, s, m;
        int p;
        exp_t e;
        va = longint'(ai[W-2:0]);
        if (ai[W-1]) va = -va;
        vb = longint'(bi[W-2:0]);
        if (bi[W-1] ^ opi) vb = -vb;
        s = va + vb;
        m = (s < 0) ? -s : s;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        e.z   = (m == 0);
        e.pos = PW'(p);
        e.res = {(s < 0) ? 1'b1 : 1'b0, W'(m << (W - 1 - p))};
        e.tag = t;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = {1'b1, {(W-1){1'b0}}};
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = '1;
            4:       v = {$urandom_range(0, 1) == 1, (W-1)'($urandom_range(0, 15))};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        total++; if (result !== '0) begin bad++; $display("FAIL rst_result got %h want 0", result); end
        total++; if (position !== '0) begin bad++; $display("FAIL rst_position got %0d want 0", position); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL rst_zero got %b want 0", zero); end
        total++; if (out_tag !== '0) begin bad++; $display("FAIL rst_out_tag got %h want 0", out_tag); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [7] = '{28'h0000005, 28'h0000003, 28'h0000007, 28'h8000000,
                                 28'h7FFFFFF, 28'h8000000, 28'h8000005};
        logic [W-1:0] vb [7] = '{28'h0000003, 28'h8000005, 28'h0000007, 28'h0000000,
                                 28'h7FFFFFF, 28'h0000001, 28'h0000003};
        logic         vo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W:0]   er [7] = '{29'h0800_0000, 29'h1800_0000, 29'h0, 29'h0,
                                 29'h0FFF_FFFE, 29'h0800_0000, 29'h1800_0000};
        int           ep [7] = '{3, 1, 0, 0, 27, 0, 3};
        logic         ez [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            a = va[i]; b = vb[i]; op = vo[i]; in_tag = TAG_W'(i);
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = '1; b = '1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                total++;
                if (out_valid !== (k == 2)) begin
                    bad++; $display("FAIL dir%0d_latency edge %0d got out_valid=%b want %b", i, k, out_valid, k == 2);
                end
            end
            total++;
            if (result !== er[i] || position !== PW'(ep[i]) || zero !== ez[i] || out_tag !== TAG_W'(i)) begin
                bad++;
                $display("FAIL dir%0d_value got res=%h pos=%0d z=%b tag=%0d want res=%h pos=%0d z=%b tag=%0d",
                         i, result, position, zero, out_tag, er[i], ep[i], ez[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int got  = 0;
        logic             held = 1'b0;
        logic [W:0]       held_res = '0;
        logic [TAG_W-1:0] held_tag = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 8);
            in_valid  = (sent < 6);
            a = rnd_operand(); b = rnd_operand(); op = 1'($urandom_range(0, 1));
            in_tag = TAG_W'(sent);
            @(negedge clk);
            if (c < 8) begin
                total++;
                if (in_ready !== (sent < 3)) begin bad++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, in_ready, sent < 3); end
            end
            if (c >= 8 && c < 14) begin
                total++;
                if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_throughput cycle %0d got out_valid=%b want 1", c, out_valid); end
            end
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || result !== held_res || out_tag !== held_tag) begin
                    bad++; $display("FAIL bp_hold cycle %0d got v=%b res=%h tag=%0d want v=1 res=%h tag=%0d",
                                    c, out_valid, result, out_tag, held_res, held_tag);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                e = q.pop_front();
                if (result !== e.res || position !== e.pos || zero !== e.z || out_tag !== TAG_W'(got)) begin
                    bad++; $display("FAIL bp_order got res=%h pos=%0d z=%b tag=%0d want res=%h pos=%0d z=%b tag=%0d",
                                    result, position, zero, out_tag, e.res, e.pos, e.z, got);
                end
                got++;
            end
            held     = out_valid && !out_ready;
            held_res = result;
            held_tag = out_tag;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, op, in_tag));
                sent++;
            end
        end
        total++; if (got != 6) begin bad++; $display("FAIL bp_count got %0d want 6", got); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = rnd_operand(); b = rnd_operand(); op = 1'($urandom_range(0, 1));
            in_tag = TAG_W'(i + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_in_flight got out_valid=%b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        total++; if (result !== '0 || position !== '0 || zero !== 1'b0 || out_tag !== '0) begin
            bad++; $display("FAIL mid_outputs got res=%h pos=%0d z=%b tag=%0d want all 0", result, position, zero, out_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cycle %0d got out_valid=%b want 0", k, out_valid); end
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic             prev_stall = 1'b0;
        logic [W:0]       prev_res   = '0;
        logic [TAG_W-1:0] prev_tag   = '0;
        logic [TAG_W-1:0] tag        = '0;
        for (int c = 0; c < 700 && !(c >= 500 && q.size() == 0); c++) begin
            @(posedge clk); #1;
            if (c < 500) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a  = rnd_operand();
                b  = rnd_operand();
                op = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) begin b = a; op = 1'b1; end
                in_tag    = tag;
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || result !== prev_res || out_tag !== prev_tag) begin
                    bad++; $display("FAIL rand_hold cycle %0d got v=%b res=%h tag=%0d want v=1 res=%h tag=%0d",
                                    c, out_valid, result, out_tag, prev_res, prev_tag);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_spurious cycle %0d got res=%h want no result", c, result);
                end else begin
                    e = q.pop_front();
                    if (result !== e.res || position !== e.pos || zero !== e.z || out_tag !== e.tag) begin
                        bad++; $display("FAIL rand_value cycle %0d got res=%h pos=%0d z=%b tag=%0d want res=%h pos=%0d z=%b tag=%0d",
                                        c, result, position, zero, out_tag, e.res, e.pos, e.z, e.tag);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_tag   = out_tag;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, op, in_tag));
                tag++;
            end
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain got %0d pending want 0", q.size()); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
